game_tick_gen: RTL

Parametrised tick and score engine for the Dino game. It replaces the free-running single-toggle score divider. It runs from the 27 MHz system clock and produces one-cycle score and obstacle tick pulses, gated by `gameon`. It also keeps a BCD score for the OLED renderer and a difficulty level that shortens the obstacle tick period as the score grows. It sits between the game FSM, which drives `gameon`/`clear`, and the obstacle/render logic, which consumes the ticks and the score.

---
 rtl/game_pkg.sv | 13 +
 rtl/tick_divider.sv | 42 ++++
 rtl/game_tick_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared Dino-game constants and types: system clock rate, default tick divisors, BCD digit type.
package game_pkg;

    localparam int CLK_HZ             = 27_000_000;
    localparam int SCORE_DIV_DFLT     = 3_000_000;
    localparam int OBST_BASE_DIV_DFLT = 2_700_000;
    localparam int OBST_STEP_DFLT     = 225_000;
    localparam int OBST_MIN_DIV_DFLT  = 900_000;
    localparam int LEVEL_MAX_DFLT     = 7;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated period divider with a registered one-cycle tick.
// The >= terminal compare lets a period that shrinks mid-count fire on the next enabled cycle.
module tick_divider #(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick,
    output logic             fire
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        // fire is the edge that raises tick; callers use it to update state on that same edge
        fire   = en && !clr && (cnt_q >= (period - DIV_W'(1)));
        cnt_d  = cnt_q;
        tick_d = fire;
        if (clr || fire) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_tick_gen.sv
// Score/obstacle tick engine: two gated dividers, a BCD score with wrap pulse,
// and a saturating difficulty level that shortens the obstacle period.
module game_tick_gen
    import game_pkg::*;
#(
    parameter int SCORE_DIV     = SCORE_DIV_DFLT,
    parameter int OBST_BASE_DIV = OBST_BASE_DIV_DFLT,
    parameter int OBST_STEP     = OBST_STEP_DFLT,
    parameter int OBST_MIN_DIV  = OBST_MIN_DIV_DFLT,
    parameter int LEVEL_MAX     = LEVEL_MAX_DFLT,
    parameter int DIGITS        = 4,
    parameter int DIV_W         = 22
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           gameon,
    input  logic                           clear,
    output logic                           score_tick,
    output logic                           obstacle_tick,
    output logic [4*DIGITS-1:0]            score_bcd,
    output logic [$clog2(LEVEL_MAX+1)-1:0] level,
    output logic                           score_wrap
);

    localparam int LVL_W = $clog2(LEVEL_MAX + 1);
    localparam int PW    = DIV_W + 4;

    logic [4*DIGITS-1:0] score_q, score_d, score_inc;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                wrap_q, wrap_d;
    logic                score_fire, obst_fire_unused;
    logic                all_nines;
    logic [PW-1:0]       obst_dec, obst_p;
    logic [DIV_W-1:0]    obst_period;

    tick_divider #(.DIV_W(DIV_W)) u_score_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .en     (gameon),
        .period (DIV_W'(SCORE_DIV)),
        .tick   (score_tick),
        .fire   (score_fire)
    );

    tick_divider #(.DIV_W(DIV_W)) u_obst_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .en     (gameon),
        .period (obst_period),
        .tick   (obstacle_tick),
        .fire   (obst_fire_unused)
    );

    // Clamp before subtracting so a large level never underflows the period.
    always_comb begin
        obst_dec = PW'(level_q) * PW'(OBST_STEP);
        if (obst_dec >= (PW'(OBST_BASE_DIV) - PW'(OBST_MIN_DIV))) begin
            obst_p = PW'(OBST_MIN_DIV);
        end else begin
            obst_p = PW'(OBST_BASE_DIV) - obst_dec;
        end
        obst_period = DIV_W'(obst_p);
    end

    always_comb begin
        bcd_digit_t dig;
        logic       carry;
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = score_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    dig = 4'd0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            score_inc[4*i +: 4] = dig;
        end
        all_nines = carry;
    end

    always_comb begin
        score_d = score_q;
        level_d = level_q;
        wrap_d  = 1'b0;
        if (clear) begin
            score_d = '0;
            level_d = '0;
        end else if (score_fire) begin
            score_d = score_inc;
            wrap_d  = all_nines;
            if ((score_q[7:0] == 8'h99) && !all_nines && (level_q != LVL_W'(LEVEL_MAX))) begin
                level_d = level_q + LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
            level_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            score_q <= score_d;
            level_q <= level_d;
            wrap_q  <= wrap_d;
        end
    end

    assign score_bcd  = score_q;
    assign level      = level_q;
    assign score_wrap = wrap_q;

endmodule
